bias_bram_reader: RTL and testbench
===================================

BIAS_BRAM_READER -- requirements
Module: bias_bram_reader

Interface
REQ-001 SHALL have parameter MEM_SIZE, default 40: RAM word width in bits.
REQ-002 SHALL have parameter MEM_DEPTH, default 49: RAM depth in words.
REQ-003 SHALL have parameter B_BW, default 8: bias width; MEM_SIZE/B_BW = 5 biases per word.
REQ-004 clk  input  1  single clock; all logic on posedge clk.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 start  input  1  one-cycle request pulse.
REQ-007 base_addr  input  6  first word address.
REQ-008 num_words  input  6  words to read, 0..MEM_DEPTH.
REQ-009 busy  output  1  high from accepted start until done.
REQ-010 done  output  1  one-cycle pulse at end of request.
REQ-011 err  output  1  valid with done; request rejected.
REQ-012 ram_en, ram_regce  output  1 each  RAM port enable, output-register enable.
REQ-013 ram_addr  output  6  RAM read address.
REQ-014 ram_dout  input  MEM_SIZE  RAM read data, 2-cycle latency (registered output).
REQ-015 bias_out  output  B_BW  unpacked bias.
REQ-016 bias_valid / bias_ready  output / input  1 each  stream handshake; transfer when both high.
REQ-017 bias_last  output  1  high with the final bias of a request.

Function
REQ-018 States: IDLE, FETCH, DRAIN, DONE; start accepted only in IDLE, ignored otherwise.
REQ-019 IDLE->FETCH on start with num_words>0 and request legal; num_words==0 -> DONE, done=1 err=0 next cycle, no RAM access.
REQ-020 FETCH: issues one read per cycle (ram_en=1, ram_addr=current) while credits>0; address increments by 1 per issue.
REQ-021 ram_regce SHALL be high exactly one cycle after each issue; data captured from ram_dout exactly two cycles after issue.
REQ-022 Credits = 4 - (word FIFO occupancy + reads in flight); FIFO (4 words) SHALL never overflow under any bias_ready pattern.
REQ-023 FETCH->DRAIN after num_words issued; DRAIN->DONE when FIFO, in-flight and unpack register empty and last bias transferred.
REQ-024 DONE lasts one cycle with done=1, then IDLE; busy=1 in FETCH/DRAIN/DONE.
REQ-025 Unpack: each word emits 5 biases, bits [B_BW-1:0] first, ascending; next slice advances only on handshake.
REQ-026 bias_out/bias_valid SHALL hold stable while bias_valid=1 and bias_ready=0.
REQ-027 Zero-bubble: with bias_ready held high, one bias per cycle after first-data latency (first bias_valid 3 cycles after start).
REQ-028 bias_last=1 only on slice 4 of the last word; total transfers = 5*num_words.
REQ-029 ram_en=0 and ram_addr=0 on cycles with no issue.

Reset
REQ-030 On rst: state IDLE; busy, done, err, ram_en, ram_regce, bias_valid, bias_last = 0; ram_addr, bias_out = 0; FIFO, credits, counters cleared.
REQ-031 Reset mid-request aborts it; in-flight RAM data discarded; no done pulse generated.

Configuration
REQ-032 Macro BIAS_RD_WRAP_EN defined: ram_addr wraps MEM_DEPTH-1 -> 0; every request with num_words<=MEM_DEPTH is legal.
REQ-033 Macro undefined: request with base_addr+num_words>MEM_DEPTH is rejected -> DONE next cycle, done=1 err=1, no RAM access, no bias output.
REQ-034 err=0 whenever done=1 for legal requests, in both builds.

Verification
REQ-035 start, base 0, num 2, ready=1 -> ram_addr 0,1 on consecutive cycles; 10 biases in 10 cycles, bias_last on 10th; done one cycle later.
REQ-036 num 3, ready toggling 1/0 -> 15 biases in order, stable during stalls, ram_en never issues with credits 0.
REQ-037 ready=0 for 20 cycles, num 10 -> at most 4 issues before first transfer; no data lost once ready=1.
REQ-038 base 47, num 4: WRAP_EN defined -> addresses 47,48,0,1; undefined -> done=1 err=1, ram_en never high.
REQ-039 num 0 -> done pulse after one cycle, err=0; start while busy -> ignored.
REQ-040 rst asserted mid-FETCH -> all outputs 0 immediately; next start behaves as fresh request.

Source files
------------

// File: rtl/bias_bram_reader.sv
// Streams num_words RAM words starting at base_addr as B_BW-bit biases, low slice first.
// Define BIAS_RD_WRAP_EN to wrap addresses at MEM_DEPTH instead of rejecting overrunning requests.
module bias_bram_reader #(
  parameter int MEM_SIZE  = 40,
  parameter int MEM_DEPTH = 49,
  parameter int B_BW      = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [5:0]          base_addr,
  input  logic [5:0]          num_words,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic                ram_en,
  output logic                ram_regce,
  output logic [5:0]          ram_addr,
  input  logic [MEM_SIZE-1:0] ram_dout,
  output logic [B_BW-1:0]     bias_out,
  output logic                bias_valid,
  input  logic                bias_ready,
  output logic                bias_last
);

  localparam int NSL = MEM_SIZE / B_BW;
  localparam int SW  = $clog2(NSL);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

  state_t              state;
  logic [5:0]          cur_addr;
  logic [5:0]          rem;
  logic [5:0]          ld_rem;
  logic                cap_q;
  logic [MEM_SIZE-1:0] fifo_mem [4];
  logic [1:0]          wp, rp;
  logic [2:0]          fcnt;
  logic [MEM_SIZE-1:0] word_q;
  logic [SW-1:0]       slice_q;
  logic                uv, ulast;

  logic                req_ok, can_issue, hs, end_slice, push, pop;
  logic                cur_v, cur_last;
  logic [SW-1:0]       cur_slice;
  logic [MEM_SIZE-1:0] cur_word;
  logic [2:0]          occ;

  function automatic logic [5:0] addr_inc(input logic [5:0] a);
`ifdef BIAS_RD_WRAP_EN
    return (a == 6'(MEM_DEPTH - 1)) ? '0 : a + 6'd1;
`else
    return a + 6'd1;
`endif
  endfunction

`ifdef BIAS_RD_WRAP_EN
  assign req_ok = (int'(num_words) <= MEM_DEPTH) && (int'(base_addr) < MEM_DEPTH);
`else
  assign req_ok = (int'(base_addr) + int'(num_words) <= MEM_DEPTH);
`endif

  // A word arriving while nothing is being unpacked is presented straight from ram_dout
  // for its first slice, so the first bias appears in the same cycle the data does.
  always_comb begin
    cur_v     = uv | cap_q;
    cur_slice = uv ? slice_q : '0;
    cur_word  = uv ? word_q : ram_dout;
    cur_last  = uv ? ulast : (ld_rem == 6'd1);
    hs        = cur_v & bias_ready;
    end_slice = (cur_slice == SW'(NSL - 1));
    pop       = uv & hs & end_slice & (fcnt != 3'd0);
    push      = cap_q & uv & ~(hs & end_slice & (fcnt == 3'd0));
    occ       = fcnt + 3'(uv) + 3'(ram_en) + 3'(ram_regce) + 3'(cap_q);
    can_issue = (occ < 3'd4);
    bias_valid = cur_v;
    bias_last  = cur_v & cur_last & end_slice;
    bias_out   = '0;
    if (cur_v) bias_out = cur_word[B_BW*int'(cur_slice) +: B_BW];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      ram_en    <= 1'b0;
      ram_regce <= 1'b0;
      ram_addr  <= '0;
      cur_addr  <= '0;
      rem       <= '0;
      ld_rem    <= '0;
      cap_q     <= 1'b0;
      wp        <= '0;
      rp        <= '0;
      fcnt      <= '0;
      word_q    <= '0;
      slice_q   <= '0;
      uv        <= 1'b0;
      ulast     <= 1'b0;
      for (int unsigned i = 0; i < 4; i++) fifo_mem[i] <= '0;
    end else begin
      ram_regce <= ram_en;
      cap_q     <= ram_regce;
      ram_en    <= 1'b0;
      ram_addr  <= '0;
      done      <= 1'b0;
      err       <= 1'b0;

      case (state)
        IDLE: if (start) begin
          busy <= 1'b1;
          if (num_words == 6'd0) begin
            state <= DONE;
            done  <= 1'b1;
          end else if (!req_ok) begin
            state <= DONE;
            done  <= 1'b1;
            err   <= 1'b1;
          end else begin
            ram_en   <= 1'b1;
            ram_addr <= base_addr;
            cur_addr <= addr_inc(base_addr);
            rem      <= num_words - 6'd1;
            ld_rem   <= num_words;
            state    <= (num_words == 6'd1) ? DRAIN : FETCH;
          end
        end
        FETCH: if (can_issue) begin
          ram_en   <= 1'b1;
          ram_addr <= cur_addr;
          cur_addr <= addr_inc(cur_addr);
          rem      <= rem - 6'd1;
          if (rem == 6'd1) state <= DRAIN;
        end
        DRAIN: if (hs && bias_last) begin
          state <= DONE;
          done  <= 1'b1;
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase

      if (!uv) begin
        if (cap_q) begin
          word_q  <= ram_dout;
          uv      <= 1'b1;
          slice_q <= hs ? SW'(1) : '0;
          ulast   <= (ld_rem == 6'd1);
          ld_rem  <= ld_rem - 6'd1;
        end
      end else if (hs) begin
        if (end_slice) begin
          if (fcnt != 3'd0) begin
            word_q  <= fifo_mem[rp];
            slice_q <= '0;
            ulast   <= (ld_rem == 6'd1);
            ld_rem  <= ld_rem - 6'd1;
          end else if (cap_q) begin
            word_q  <= ram_dout;
            slice_q <= '0;
            ulast   <= (ld_rem == 6'd1);
            ld_rem  <= ld_rem - 6'd1;
          end else begin
            uv <= 1'b0;
          end
        end else begin
          slice_q <= slice_q + SW'(1);
        end
      end

      if (push) begin
        fifo_mem[wp] <= ram_dout;
        wp           <= wp + 2'd1;
      end
      if (pop) rp <= rp + 2'd1;
      fcnt <= fcnt + 3'(push) - 3'(pop);
    end
  end

endmodule

// File: tb/tb_bias_bram_reader.sv
// Randomized bench for bias_bram_reader against a word-list/slice reference model and a 2-cycle BRAM model.
module tb_bias_bram_reader;

  localparam int DEPTH = 49;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [5:0]  base_addr, num_words;
  logic        busy, done, err, ram_en, ram_regce;
  logic [5:0]  ram_addr;
  logic [39:0] ram_dout;
  logic [7:0]  bias_out;
  logic        bias_valid, bias_ready, bias_last;

  int n_checks = 0;
  int n_err    = 0;

  logic [39:0] mem [DEPTH];
  logic [5:0]  addr_q;

  bias_bram_reader #(.MEM_SIZE(40), .MEM_DEPTH(DEPTH), .B_BW(8)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .num_words(num_words),
    .busy(busy), .done(done), .err(err), .ram_en(ram_en), .ram_regce(ram_regce),
    .ram_addr(ram_addr), .ram_dout(ram_dout), .bias_out(bias_out), .bias_valid(bias_valid),
    .bias_ready(bias_ready), .bias_last(bias_last)
  );

  always #5 clk = ~clk;

  // BRAM: address registered on ram_en, output register loaded on ram_regce.
  always @(posedge clk) begin
    if (ram_en) addr_q <= ram_addr;
    if (ram_regce) ram_dout <= mem[(int'(addr_q) < DEPTH) ? addr_q : 6'd0];
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic rdy(input int mode, input int k);
    case (mode)
      0:       return 1'b1;
      1:       return k[0];
      2:       return k > 20;
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  task automatic do_req(input int base, input int num, input int mode, input bit poke);
    int exp_addr [64];
    logic [5:0] got_addr [64];
    int a, n_iss, n_xfer, first_k, last_k, done_k, iss_at_first;
    int idle_bad, stab_bad, credit_bad;
    bit legal, exp_err, got_done, got_err, prev_stall;
    logic [7:0] prev_bias, exp_b;
    int widx, sl;

`ifdef BIAS_RD_WRAP_EN
    legal = (num <= DEPTH);
`else
    legal = (base + num <= DEPTH);
`endif
    exp_err = (num != 0) && !legal;
    a = base;
    for (int i = 0; i < num; i++) begin
      exp_addr[i] = a;
`ifdef BIAS_RD_WRAP_EN
      a = (a + 1) % DEPTH;
`else
      a = a + 1;
`endif
    end
    n_iss = 0; n_xfer = 0; first_k = -1; last_k = -1; done_k = -1; iss_at_first = -1;
    idle_bad = 0; stab_bad = 0; credit_bad = 0; got_done = 0; got_err = 0;
    prev_stall = 0; prev_bias = '0;

    @(negedge clk);
    start = 1'b1; base_addr = 6'(base); num_words = 6'(num); bias_ready = rdy(mode, 0);
    for (int k = 1; k < 3000; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (poke && k == 2) begin
        start = 1'b1; base_addr = 6'd0; num_words = 6'd1;
      end
      bias_ready = rdy(mode, k);
      if (ram_en) begin
        if (n_iss < 64) got_addr[n_iss] = ram_addr;
        n_iss++;
        if (n_iss - n_xfer / 5 > 4) credit_bad++;
      end else if (ram_addr != 6'd0) idle_bad++;
      if (prev_stall && (!bias_valid || bias_out != prev_bias)) stab_bad++;
      prev_stall = bias_valid && !bias_ready;
      prev_bias  = bias_out;
      if (bias_valid && bias_ready) begin
        widx = n_xfer / 5;
        sl   = n_xfer % 5;
        exp_b = (widx < num) ? 8'(mem[exp_addr[widx]] >> (8 * sl)) : 8'hxx;
        check("bias", bias_out, exp_b);
        check("last", bias_last, n_xfer == 5 * num - 1);
        if (first_k < 0) begin first_k = k; iss_at_first = n_iss; end
        last_k = k;
        n_xfer++;
      end
      if (done) begin
        got_done = 1; got_err = err; done_k = k;
        check("busy_done", busy, 1'b1);
        break;
      end
    end
    check("done_seen", got_done, 1'b1);
    check("err", got_err, exp_err);
    check("n_issue", n_iss, legal ? num : 0);
    check("n_xfer", n_xfer, legal ? 5 * num : 0);
    if (legal) for (int i = 0; i < num && i < 64; i++) check("addr", got_addr[i], exp_addr[i]);
    check("idle_addr", idle_bad, 0);
    check("stall_stable", stab_bad, 0);
    check("credit", credit_bad, 0);
    if (num == 0 || !legal) check("done_lat", done_k, 1);
    else begin
      check("done_after_last", done_k, last_k + 1);
      if (mode == 0) begin
        check("first_lat", first_k, 3);
        check("stream_span", last_k - first_k, 5 * num - 1);
      end
      if (mode == 2) check("prefetch_le4", iss_at_first <= 4, 1'b1);
    end
    @(negedge clk);
    check("idle_after", {busy, done}, 2'b00);
  endtask

  initial begin
    int b, n, done_cnt;
    for (int i = 0; i < DEPTH; i++) mem[i] = 40'({$urandom(), $urandom()});
    rst = 1'b1; start = 1'b0; base_addr = '0; num_words = '0; bias_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outs", {busy, done, err, ram_en, ram_regce, bias_valid, bias_last, ram_addr, bias_out}, '0);
    rst = 1'b0;
    @(negedge clk);

    do_req(0, 2, 0, 0);
    do_req(5, 3, 1, 0);
    do_req(10, 10, 2, 0);
    do_req(47, 4, 0, 0);
    do_req(20, 0, 0, 0);
    do_req(30, 5, 0, 1);
    do_req(40, 20, 3, 0);

    // abort mid-fetch with asynchronous reset
    @(negedge clk);
    start = 1'b1; base_addr = 6'd3; num_words = 6'd10; bias_ready = 1'b0;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_outs", {busy, done, err, ram_en, ram_regce, bias_valid, bias_last, ram_addr, bias_out}, '0);
    @(negedge clk); rst = 1'b0;
    done_cnt = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (done || bias_valid || busy) done_cnt++;
    end
    check("abort_quiet", done_cnt, 0);

    do_req(1, 3, 0, 0);
    for (int r = 0; r < 6; r++) begin
      b = $urandom_range(0, DEPTH - 1);
      n = $urandom_range(1, DEPTH - b);
      do_req(b, n, 3, 0);
    end
    do_req(0, 49, 3, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
